hazard_stall_unit: RTL
======================

# hazard_stall_unit

Producer-side hazard controller for the 5-stage MIPS pipeline. It covers every hazard that register forwarding cannot resolve:
- **Load-use:** inserts a one-cycle bubble when an instruction in ID needs a load result that is still in EX.
- **Branch/jump:** flushes younger stages when a branch or jump resolves taken in MEM.
- **Mult/div busy:** tracks the multi-cycle mult/div unit with a counter-based state machine and stalls HI/LO consumers until the result is ready.

It sits beside the forwarding logic and drives the PC and pipeline-register write-enable and flush controls.

## Interface
Parameters:
- `MD_LATENCY`, 8: cycles HI/LO stay busy after a mult/div leaves EX (legal range 2..31).
- `CNT_W`, 16: width of the stall performance counter.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `id_Ra`  in  5  rs field of the instruction in ID.
- `id_Rb`  in  5  rt field of the instruction in ID.
- `id_useRa`  in  1  ID instruction reads Ra.
- `id_useRb`  in  1  ID instruction reads Rb.
- `id_rdHiLo`  in  1  ID instruction is mfhi/mflo.
- `id_mdOp`  in  1  ID instruction is mult/multu/div/divu.
- `ex_Rw`  in  5  destination register of the instruction in EX.
- `ex_RegWr`  in  1  EX instruction writes the register file.
- `ex_MemRd`  in  1  EX instruction is a load.
- `ex_mdStart`  in  1  a mult/div is in EX this cycle.
- `mem_BranchTaken`  in  1  branch/jump in MEM resolved taken.
- `pc_Wr`  out  1  PC write enable.
- `ifid_Wr`  out  1  IF/ID register write enable.
- `ifid_Flush`  out  1  clear IF/ID to a nop.
- `idex_Flush`  out  1  clear ID/EX to a nop.
- `exmem_Flush`  out  1  clear EX/MEM to a nop.
- `md_busy`  out  1  HI/LO result pending.
- `stall_cnt`  out  `CNT_W`  stall cycles counted; present only with `HAZ_STALL_CNT_EN`.

## Operation
The block has two states, IDLE and MD_BUSY, and a 5-bit down-counter `md_cnt`. `md_busy` is 1 exactly when the state is MD_BUSY.

Internal qualified signals:
- `md_go = ex_mdStart && !mem_BranchTaken`. A mult/div in EX is younger than a taken branch in MEM and is squashed, so it must not start the counter.
- `lu = ex_MemRd && ex_RegWr && ex_Rw != 0 && ((id_useRa && ex_Rw == id_Ra) || (id_useRb && ex_Rw == id_Rb))`.
- `md_hz = md_busy && (id_rdHiLo || id_mdOp)`.

State transitions:
- `md_go` in any state: go to MD_BUSY and load `md_cnt = MD_LATENCY-1`. If this happens while already in MD_BUSY, the counter restarts. The stall logic prevents this case; the block still handles it defensively.
- MD_BUSY with `md_cnt != 0`: decrement `md_cnt`.
- MD_BUSY with `md_cnt == 0` and no `md_go`: return to IDLE.
- A taken branch does not disturb MD_BUSY. The older mult/div is already committed and must complete.

Output decode (combinational from state and inputs, priority order):
1. `mem_BranchTaken`: `ifid_Flush = idex_Flush = exmem_Flush = 1`, `pc_Wr = ifid_Wr = 1`. This overrides any stall.
2. `lu || md_hz`: `pc_Wr = ifid_Wr = 0`, `idex_Flush = 1`, other flushes 0.
3. Otherwise: `pc_Wr = ifid_Wr = 1`, all flushes 0.

While `rst` is high, outputs are forced to `pc_Wr = ifid_Wr = 1`, all flushes 0 and `md_busy = 0`, regardless of the other inputs.

## Timing
- Reset, one edge with `rst = 1`: state IDLE, `md_cnt = 0`, `stall_cnt = 0`.
- Reset takes effect mid-operation. A pending MD_BUSY is abandoned and no stall is carried past reset.
- Stall and flush outputs respond in the same cycle as their inputs, with zero latency.
- Load-use stall lasts exactly 1 cycle. The bubble occupies EX next cycle, so `lu` self-clears.
- `md_busy`: with `md_go` at cycle t, `md_busy = 1` in cycles t+1 through t+`MD_LATENCY`, then 0 at t+`MD_LATENCY`+1.
- An mfhi in ID during cycle t+`MD_LATENCY`+1 proceeds without a stall.
- `lu` and `md_hz` together produce a single combined stall. There is no double counting.

## Configuration
- `HAZ_STALL_CNT_EN` defined:
  - `stall_cnt` port exists.
  - It increments by 1 on every edge where `pc_Wr == 0` and `rst == 0`.
  - It saturates at all-ones and does not wrap.
- `HAZ_STALL_CNT_EN` undefined: the port and the counter logic are absent. All other behaviour is identical.

## Test plan
- **Load-use:** `ex_MemRd = 1`, `ex_RegWr = 1`, `ex_Rw = 8`, `id_Ra = 8`, `id_useRa = 1` -> `pc_Wr = 0`, `ifid_Wr = 0`, `idex_Flush = 1` for 1 cycle. Repeat with `ex_Rw = 0` or `id_useRa = 0` -> no stall.
- **Mult then mfhi:** with `MD_LATENCY = 8`, `ex_mdStart` at t and `id_rdHiLo = 1` from t+1 -> stall in t+1..t+8, `pc_Wr = 1` at t+9, `md_busy` falls at t+9.
- **Branch vs load-use:** `mem_BranchTaken` and `lu` in the same cycle -> all three flushes 1, `pc_Wr = 1`, no stall.
- **Branch vs mult start:** `mem_BranchTaken` with `ex_mdStart` -> `md_busy` stays 0 next cycle. `mem_BranchTaken` while MD_BUSY -> countdown continues unchanged.
- **Reset mid-operation:** `rst` at t+3 of an MD_BUSY period -> `md_busy = 0` after the edge, and a subsequent mfhi is not stalled.
- **Counter (with `HAZ_STALL_CNT_EN`):** 5 load-use stalls -> `stall_cnt = 5`. Force `CNT_W = 2` with 6 stall cycles -> holds 3.

Source files
------------

// File: rtl/hazard_stall_unit_if.sv
// ============================================================================
//  Module      : hazard_stall_unit_if
//  Description : Pipeline-side signal bundle for the hazard/stall controller.
//                The "master" side drives ID/EX/MEM pipeline status and
//                receives the PC/pipeline-register controls. The "slave"
//                side is the hazard controller itself.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface hazard_stall_unit_if;

    // ID stage instruction info
    logic [4:0] id_Ra;
    logic [4:0] id_Rb;
    logic       id_useRa;
    logic       id_useRb;
    logic       id_rdHiLo;
    logic       id_mdOp;

    // EX stage instruction info
    logic [4:0] ex_Rw;
    logic       ex_RegWr;
    logic       ex_MemRd;
    logic       ex_mdStart;

    // MEM stage branch resolution
    logic       mem_BranchTaken;

    // Pipeline controls
    logic       pc_Wr;
    logic       ifid_Wr;
    logic       ifid_Flush;
    logic       idex_Flush;
    logic       exmem_Flush;
    logic       md_busy;

    modport master (
        output id_Ra, id_Rb, id_useRa, id_useRb, id_rdHiLo, id_mdOp,
        output ex_Rw, ex_RegWr, ex_MemRd, ex_mdStart,
        output mem_BranchTaken,
        input  pc_Wr, ifid_Wr, ifid_Flush, idex_Flush, exmem_Flush, md_busy
    );

    modport slave (
        input  id_Ra, id_Rb, id_useRa, id_useRb, id_rdHiLo, id_mdOp,
        input  ex_Rw, ex_RegWr, ex_MemRd, ex_mdStart,
        input  mem_BranchTaken,
        output pc_Wr, ifid_Wr, ifid_Flush, idex_Flush, exmem_Flush, md_busy
    );

endinterface

`default_nettype wire

// File: rtl/hazard_stall_unit.sv
// ============================================================================
//  Module      : hazard_stall_unit
//  Description : Hazard controller for the 5-stage MIPS pipeline. Handles the
//                hazards forwarding cannot resolve: load-use bubbles, taken
//                branch/jump flushes and HI/LO consumers waiting on the
//                multi-cycle mult/div unit.
//                Optional feature macro: HAZ_STALL_CNT_EN adds the saturating
//                stall_cnt performance counter port.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_stall_unit #(
    parameter int MD_LATENCY = 8,   // HI/LO busy cycles after mult/div leaves EX (2..31)
    parameter int CNT_W      = 16   // stall performance counter width
) (
    input  wire logic              clk,
    input  wire logic              rst,
    hazard_stall_unit_if.slave     bus
`ifdef HAZ_STALL_CNT_EN
    ,
    output logic [CNT_W-1:0]       stall_cnt
`endif
);

    // Parameter sanity: an out-of-range latency would not fit the 5-bit
    // countdown, and a zero-width counter is meaningless.
    if (MD_LATENCY < 2 || MD_LATENCY > 31 || CNT_W < 1) begin : g_param_err
        $error("hazard_stall_unit: MD_LATENCY must be 2..31 and CNT_W >= 1");
    end

    // Countdown reload: busy for MD_LATENCY cycles means reload with L-1 and
    // leave MD_BUSY on the edge where the counter already reads zero.
    localparam logic [4:0] C_MD_RELOAD = 5'(MD_LATENCY - 1);

    typedef enum logic [0:0] {
        S_IDLE    = 1'b0,
        S_MD_BUSY = 1'b1
    } state_t;

    state_t     r_state;
    logic [4:0] r_md_cnt;

    logic w_md_go;
    logic w_ra_hit;
    logic w_rb_hit;
    logic w_lu;
    logic w_md_hz;
    logic w_busy;

    logic w_pc_wr;
    logic w_ifid_wr;
    logic w_ifid_flush;
    logic w_idex_flush;
    logic w_exmem_flush;

    // A mult/div in EX behind a taken branch in MEM is squashed and must
    // never start the busy window.
    assign w_md_go  = bus.ex_mdStart && !bus.mem_BranchTaken;

    // Load-use: the EX load targets a non-zero register the ID instruction reads.
    assign w_ra_hit = bus.id_useRa && (bus.ex_Rw == bus.id_Ra);
    assign w_rb_hit = bus.id_useRb && (bus.ex_Rw == bus.id_Rb);
    assign w_lu     = bus.ex_MemRd && bus.ex_RegWr && (bus.ex_Rw != 5'd0)
                      && (w_ra_hit || w_rb_hit);

    // HI/LO consumers and new mult/div ops must wait for the pending result.
    // Reset is synchronous, so busy is masked while rst is asserted.
    assign w_busy   = (r_state == S_MD_BUSY) && !rst;
    assign w_md_hz  = w_busy && (bus.id_rdHiLo || bus.id_mdOp);

    // Mult/div busy tracker: a counter-driven two-state machine.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_md_cnt <= 5'd0;
        end else if (w_md_go) begin
            // Also restarts the window if a new op sneaks in while busy.
            r_state  <= S_MD_BUSY;
            r_md_cnt <= C_MD_RELOAD;
        end else if (r_state == S_MD_BUSY) begin
            if (r_md_cnt != 5'd0) begin
                r_md_cnt <= r_md_cnt - 5'd1;
            end else begin
                r_state  <= S_IDLE;
            end
        end
    end

    // Zero-latency control decode: branch flush beats any stall.
    always_comb begin
        w_pc_wr       = 1'b1;
        w_ifid_wr     = 1'b1;
        w_ifid_flush  = 1'b0;
        w_idex_flush  = 1'b0;
        w_exmem_flush = 1'b0;
        if (rst) begin
            // Hold the pipeline in its free-running default during reset.
        end else if (bus.mem_BranchTaken) begin
            w_ifid_flush  = 1'b1;
            w_idex_flush  = 1'b1;
            w_exmem_flush = 1'b1;
        end else if (w_lu || w_md_hz) begin
            w_pc_wr       = 1'b0;
            w_ifid_wr     = 1'b0;
            w_idex_flush  = 1'b1;
        end
    end

    assign bus.pc_Wr       = w_pc_wr;
    assign bus.ifid_Wr     = w_ifid_wr;
    assign bus.ifid_Flush  = w_ifid_flush;
    assign bus.idex_Flush  = w_idex_flush;
    assign bus.exmem_Flush = w_exmem_flush;
    assign bus.md_busy     = w_busy;

`ifdef HAZ_STALL_CNT_EN
    logic [CNT_W-1:0] r_stall_cnt;

    // Count every stalled cycle once (combined hazards still stall once),
    // saturating rather than wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (!w_pc_wr && (r_stall_cnt != {CNT_W{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

endmodule

`default_nettype wire
